// File: rtl/extio8x4_pkg.sv
// extio8x4_pkg: shared state, channel and burst-length encodings for the extio8x4 initiator
package extio8x4_pkg;

    typedef enum logic [2:0] {STAT, CMD1, CMD2, DH, DL, DZ} state_t;

    localparam logic [1:0] CH_RX0 = 2'b00;
    localparam logic [1:0] CH_TX0 = 2'b01;
    localparam logic [1:0] CH_RX1 = 2'b10;
    localparam logic [1:0] CH_TX1 = 2'b11;

    localparam logic [1:0] BL1 = 2'b00;
    localparam logic [1:0] BL2 = 2'b01;
    localparam logic [1:0] BL4 = 2'b10;

    // Largest power of two not exceeding min(max_burst, avail); avail is always >= 1 here
    function automatic logic [1:0] burst_code(input int max_burst, input int avail);
        return (max_burst >= 4 && avail >= 4) ? BL4 : (max_burst >= 2 && avail >= 2) ? BL2 : BL1;
    endfunction

    function automatic logic [2:0] burst_len(input logic [1:0] code);
        return 3'd1 << code;
    endfunction

endpackage

// File: rtl/extio8x4_axis_fifo.sv
// extio8x4_axis_fifo: byte FIFO with extra-bit pointers and occupancy count, no fall-through
module extio8x4_axis_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/extio8x4_ifsm_burst.sv
// extio8x4_ifsm_burst: extio initiator bridging two AXIS write and two AXIS read streams,
// with per-channel FIFOs, round-robin arbitration and power-of-two bursts.
module extio8x4_ifsm_burst
    import extio8x4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       axis_rx0_tvalid,
    output logic       axis_rx0_tready,
    input  logic [7:0] axis_rx0_tdata8,
    input  logic       axis_rx1_tvalid,
    output logic       axis_rx1_tready,
    input  logic [7:0] axis_rx1_tdata8,
    output logic       axis_tx0_tvalid,
    input  logic       axis_tx0_tready,
    output logic [7:0] axis_tx0_tdata8,
    output logic       axis_tx1_tvalid,
    input  logic       axis_tx1_tready,
    output logic [7:0] axis_tx1_tdata8,
    input  logic [3:0] iodata4_i,
    input  logic [3:0] iodata4_s,
    output logic [3:0] iodata4_o,
    output logic [3:0] iodata4_e,
    output logic [3:0] iodata4_t,
    output logic       ioreq1_o,
    output logic       ioreq2_o,
    input  logic       ioack_s,
    output logic       busy_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state, state_n;
    logic          ack_q, rise, fall, launch, done, wr;
    logic [1:0]    last_grant, grant, cur_ch, cur_code, launch_code;
    logic [2:0]    cnt;
    logic [3:0]    hi, req, push, pop, full, empty;
    logic [7:0]    din [4];
    logic [7:0]    dout [4];
    logic [7:0]    wbyte;
    logic [CW-1:0] count [4];
    logic [CW-1:0] avail [4];

    // Channel index equals channel code; status bit for code c is c^1
    for (genvar c = 0; c < 4; c++) begin : g_ch
        extio8x4_axis_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk), .resetn(resetn), .push(push[c]), .din(din[c]), .pop(pop[c]),
            .dout(dout[c]), .count(count[c]), .full(full[c]), .empty(empty[c])
        );
        assign avail[c] = (c % 2 == 1) ? CW'(FIFO_DEPTH) - count[c] : count[c];
        assign req[c]   = state == STAT && !iodata4_s[c ^ 1] && ((c % 2 == 1) ? !full[c] : !empty[c]);
    end

    assign rise   = ioack_s && !ack_q;
    assign fall   = !ioack_s && ack_q;
    assign launch = |req && !ioack_s;
    assign done   = state == DL && fall;
    assign wr     = !cur_ch[0];
    assign wbyte  = cur_ch[1] ? dout[2] : dout[0];

    assign push[0] = axis_rx0_tvalid && !full[0];
    assign push[1] = done && cur_ch == CH_TX0;
    assign push[2] = axis_rx1_tvalid && !full[2];
    assign push[3] = done && cur_ch == CH_TX1;
    assign pop[0]  = done && cur_ch == CH_RX0;
    assign pop[1]  = axis_tx0_tready && !empty[1];
    assign pop[2]  = done && cur_ch == CH_RX1;
    assign pop[3]  = axis_tx1_tready && !empty[3];
    assign din[0]  = axis_rx0_tdata8;
    assign din[1]  = {hi, iodata4_i};
    assign din[2]  = axis_rx1_tdata8;
    assign din[3]  = {hi, iodata4_i};

    assign axis_rx0_tready = !full[0];
    assign axis_rx1_tready = !full[2];
    assign axis_tx0_tvalid = !empty[1];
    assign axis_tx1_tvalid = !empty[3];
    assign axis_tx0_tdata8 = dout[1];
    assign axis_tx1_tdata8 = dout[3];
    assign iodata4_t       = ~iodata4_e;
    assign busy_o          = state != STAT;

    // Nearest requester after last_grant wins; offset 4 wraps back to last_grant itself
    always_comb begin
        grant = last_grant;
        for (int i = 4; i >= 1; i--)
            if (req[last_grant + 2'(i)]) grant = last_grant + 2'(i);
        launch_code = burst_code(MAX_BURST, int'(avail[grant]));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= STAT;
            ack_q <= 1'b0;
        end else begin
            state <= state_n;
            ack_q <= ioack_s;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= CH_TX1;
            cur_ch     <= CH_RX0;
            cur_code   <= BL1;
            cnt        <= '0;
            hi         <= '0;
        end else begin
            if (launch) begin
                last_grant <= grant;
                cur_ch     <= grant;
                cur_code   <= launch_code;
                cnt        <= burst_len(launch_code);
            end
            if (state == DH && rise) hi <= iodata4_i;
            if (done) cnt <= cnt - 3'd1;
        end
    end

    always_comb begin
        state_n   = state;
        ioreq1_o  = 1'b0;
        ioreq2_o  = 1'b0;
        iodata4_e = 4'h0;
        iodata4_o = 4'h0;
        case (state)
            STAT: if (launch) state_n = CMD1;
            CMD1: begin
                ioreq1_o = 1'b1;
                if (rise) state_n = CMD2;
            end
            CMD2: begin
                ioreq1_o  = 1'b1;
                ioreq2_o  = 1'b1;
                iodata4_e = 4'hF;
                iodata4_o = {cur_code, cur_ch};
                if (fall) state_n = DH;
            end
            DH: begin
                ioreq1_o  = 1'b1;
                iodata4_e = wr ? 4'hF : 4'h0;
                iodata4_o = wr ? wbyte[7:4] : 4'h0;
                if (rise) state_n = DL;
            end
            DL: begin
                ioreq1_o  = 1'b1;
                ioreq2_o  = 1'b1;
                iodata4_e = wr ? 4'hF : 4'h0;
                iodata4_o = wr ? wbyte[3:0] : 4'h0;
                if (fall) state_n = cnt > 3'd1 ? DH : DZ;
            end
            DZ: begin
                ioreq1_o = 1'b1;
                if (rise) state_n = STAT;
            end
            default: state_n = STAT;
        endcase
    end

endmodule
